mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port, 1-cycle-read-latency memory between the CPU instruction-fetch port (read-only) and the data port (read/write).
- Sits between the pipelined core's imem/dmem interfaces and a unified BRAM.
- Data has fixed priority over fetch. A starvation counter guarantees forward progress for fetch.
- Non-granted requesters see gnt low and must stall and hold their request.

Parameters:
- ALEN, 32, address width.
- XLEN, 32, data width.
- STARVE_LIMIT, 4, consecutive fetch denials after which fetch wins one cycle; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- i_req  in  1  fetch request.
- i_addr  in  ALEN  fetch address.
- i_gnt  out  1  fetch granted this cycle (combinational).
- i_rvalid  out  1  fetch read data valid.
- i_rdata  out  XLEN  fetch read data.
- d_req  in  1  data request.
- d_we  in  1  data write (1) / read (0).
- d_addr  in  ALEN  data address.
- d_wdata  in  XLEN  store data.
- d_be  in  4  store byte enables.
- d_gnt  out  1  data granted this cycle (combinational).
- d_rvalid  out  1  load data valid.
- d_rdata  out  XLEN  load data.
- m_en  out  1  memory enable.
- m_we  out  1  memory write enable.
- m_addr  out  ALEN  memory address.
- m_wdata  out  XLEN  memory write data.
- m_be  out  4  memory byte enables.
- m_rdata  in  XLEN  memory read data, valid the cycle after an m_en read.

Behaviour:

Reset:
- While rst=1: i_gnt=d_gnt=0, m_en=m_we=0, m_addr=m_wdata=0, m_be=0.
- After the first reset edge: i_rvalid=d_rvalid=0, i_rdata=d_rdata=0, starvation counter=0, response owner=NONE.
- A read granted in the cycle rst rises produces no rvalid. In-flight responses are discarded.

Grant (combinational, same cycle as request):
- starve = (cnt == STARVE_LIMIT).
- d_gnt = d_req & ~(i_req & starve).
- i_gnt = i_req & ~d_gnt.
- At most one grant per cycle. No requests means no grant and m_en=0.

Memory drive:
- m_en = i_gnt | d_gnt.
- Data granted:
  - m_addr = d_addr.
  - m_we = d_we.
  - m_wdata = d_wdata.
  - m_be = d_we ? d_be : 4'b1111.
- Fetch granted:
  - m_addr = i_addr.
  - m_we = 0.
  - m_be = 4'b1111.
  - m_wdata = 0.
- No grant: m_addr, m_wdata and m_be are 0.

Response tracking (register "owner" in {NONE, INSTR, DATA}):
- Next owner = INSTR if i_gnt; DATA if d_gnt & ~d_we; else NONE.
- Latency: a read granted in cycle N gives rvalid=1 in cycle N+1 for exactly one cycle.
- Granted writes never produce rvalid.
- i_rvalid = (owner==INSTR). d_rvalid = (owner==DATA).
- Back-to-back reads, including alternating owners, are sustained at one per cycle.

Read data:
- i_rdata = i_rvalid ? m_rdata : i_hold.
- i_hold captures m_rdata on each i_rvalid cycle.
- d_rdata / d_hold behave the same way on d_rvalid.
- Outputs therefore hold the last returned value until the next response.

Starvation counter cnt (4 bits):
- Increments when i_req & d_gnt.
- Clears when i_gnt or ~i_req.
- Saturates at STARVE_LIMIT.
- While cnt==STARVE_LIMIT and i_req=1, fetch wins over a pending data request. The data request stalls one cycle, then wins again.

Requester rules:
- Requesters hold req and address stable until gnt.
- The arbiter does not latch requests; dropping req before gnt is legal and simply cancels it.

Simultaneous events:
- Both requesters active with cnt<STARVE_LIMIT: data wins.
- A data write and a fetch read in the same cycle: the write completes; the fetch stalls.

Test Plan:
1. Reset then idle:
   - rst=1 for 2 cycles, no requests.
   - Required: all outputs 0, m_en=0 throughout, no rvalid in the cycle after reset release.
2. Fetch read:
   - i_req=1, i_addr=0x100, memory returns 0xDEADBEEF.
   - Required: i_gnt=1 same cycle; i_rvalid=1 next cycle with i_rdata=0xDEADBEEF; i_rdata still 0xDEADBEEF two cycles later with i_rvalid=0.
3. Conflict:
   - i_req and d_req (read, 0x200) asserted in the same cycle.
   - Required: d_gnt=1, i_gnt=0, m_addr=0x200; next cycle d_rvalid=1, i_gnt=1 if d_req has dropped.
4. Starvation:
   - i_req held, d_req held for 10 cycles, STARVE_LIMIT=4.
   - Required: d_gnt for cycles 0-3, i_gnt in cycle 4, d_gnt for cycles 5-8, i_gnt in cycle 9.
5. Store byte enable:
   - d_req=1, d_we=1, d_addr=0x304, d_be=4'b0100, d_wdata=0x00AB0000.
   - Required: m_we=1, m_be=4'b0100, m_wdata=0x00AB0000; d_rvalid stays 0 the next cycle.
6. Reset mid-read:
   - Grant a data read, assert rst in the same cycle.
   - Required: d_rvalid=0 in the following cycle, d_rdata=0, cnt=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port, 1-cycle-latency memory between the
// instruction-fetch port (read-only) and the data port (read/write).
// Data has fixed priority; a starvation counter lets fetch win one cycle
// after STARVE_LIMIT consecutive denials.
module mem_port_arbiter #(
    parameter int unsigned ALEN         = 32,
    parameter int unsigned XLEN         = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    // Fetch port
    input  logic            i_req,
    input  logic [ALEN-1:0] i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [XLEN-1:0] i_rdata,
    // Data port
    input  logic            d_req,
    input  logic            d_we,
    input  logic [ALEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    input  logic [3:0]      d_be,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    // Memory port
    output logic            m_en,
    output logic            m_we,
    output logic [ALEN-1:0] m_addr,
    output logic [XLEN-1:0] m_wdata,
    output logic [3:0]      m_be,
    input  logic [XLEN-1:0] m_rdata
);

    typedef enum logic [1:0] {OwnNone, OwnInstr, OwnData} owner_e;

    owner_e          owner_q, owner_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] i_hold_q, d_hold_q;
    logic            starve;

    // Same-cycle grant decision; reset suppresses all grants.
    always_comb begin
        starve = (cnt_q == 4'(STARVE_LIMIT));
        d_gnt  = ~rst & d_req & ~(i_req & starve);
        i_gnt  = ~rst & i_req & ~d_gnt;
    end

    // Steer the granted requester onto the memory port; zeros when idle.
    always_comb begin
        m_en    = i_gnt | d_gnt;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_be    = 4'b0000;
        if (d_gnt) begin
            m_addr  = d_addr;
            m_we    = d_we;
            m_wdata = d_wdata;
            m_be    = d_we ? d_be : 4'b1111;
        end else if (i_gnt) begin
            m_addr = i_addr;
            m_be   = 4'b1111;
        end
    end

    // Next response owner and starvation counter.
    always_comb begin
        owner_d = OwnNone;
        if (i_gnt) begin
            owner_d = OwnInstr;
        end else if (d_gnt && !d_we) begin
            owner_d = OwnData;
        end

        cnt_d = cnt_q;
        if (i_gnt || !i_req) begin
            cnt_d = 4'd0;
        end else if (d_gnt && (cnt_q != 4'(STARVE_LIMIT))) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // State registers; synchronous reset drops any in-flight response.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q  <= OwnNone;
            cnt_q    <= 4'd0;
            i_hold_q <= '0;
            d_hold_q <= '0;
        end else begin
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            if (i_rvalid) begin
                i_hold_q <= m_rdata;
            end
            if (d_rvalid) begin
                d_hold_q <= m_rdata;
            end
        end
    end

    // Read data passes through on the response cycle, otherwise holds the last value.
    always_comb begin
        i_rvalid = (owner_q == OwnInstr);
        d_rvalid = (owner_q == OwnData);
        i_rdata  = i_rvalid ? m_rdata : i_hold_q;
        d_rdata  = d_rvalid ? m_rdata : d_hold_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic, checked against a cycle-level behavioural model.
module tb_mem_port_arbiter;

    localparam int unsigned ALEN         = 32;
    localparam int unsigned XLEN         = 32;
    localparam int unsigned STARVE_LIMIT = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_req;
    logic [ALEN-1:0] i_addr;
    logic            i_gnt;
    logic            i_rvalid;
    logic [XLEN-1:0] i_rdata;
    logic            d_req;
    logic            d_we;
    logic [ALEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic [3:0]      d_be;
    logic            d_gnt;
    logic            d_rvalid;
    logic [XLEN-1:0] d_rdata;
    logic            m_en;
    logic            m_we;
    logic [ALEN-1:0] m_addr;
    logic [XLEN-1:0] m_wdata;
    logic [3:0]      m_be;
    logic [XLEN-1:0] m_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ALEN        (ALEN),
        .XLEN        (XLEN),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_gnt   (i_gnt),
        .i_rvalid(i_rvalid),
        .i_rdata (i_rdata),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_be    (d_be),
        .d_gnt   (d_gnt),
        .d_rvalid(d_rvalid),
        .d_rdata (d_rdata),
        .m_en    (m_en),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_be    (m_be),
        .m_rdata (m_rdata)
    );

    // Environment BRAM driven by the DUT's memory port; junk on non-read cycles.
    logic [31:0] env_mem [256];
    always @(posedge clk) begin
        if (m_en && !m_we) begin
            m_rdata <= env_mem[m_addr[9:2]];
        end else begin
            m_rdata <= $urandom;
        end
        if (m_en && m_we) begin
            for (int b = 0; b < 4; b++) begin
                if (m_be[b]) env_mem[m_addr[9:2]][8*b +: 8] <= m_wdata[8*b +: 8];
            end
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [256];
    int          mdl_waits;   // consecutive cycles fetch was refused in favour of data
    int          mdl_owner;   // 0 none, 1 fetch, 2 data response due this cycle
    logic [31:0] mdl_resp;
    logic [31:0] mdl_ihold;
    logic [31:0] mdl_dhold;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive, check against the model, then advance the model.
    task automatic step(input logic r, input logic ir, input logic [31:0] ia,
                        input logic dr, input logic dw, input logic [31:0] da,
                        input logic [31:0] dwd, input logic [3:0] dbe);
        int          winner;  // 0 none, 1 fetch, 2 data
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_be;
        logic [31:0] word;
        @(negedge clk);
        rst = r; i_req = ir; i_addr = ia;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd; d_be = dbe;
        #1;
        if (r) winner = 0;
        else if (ir && dr) winner = (mdl_waits >= int'(STARVE_LIMIT)) ? 1 : 2;
        else if (dr) winner = 2;
        else if (ir) winner = 1;
        else winner = 0;

        e_addr = 32'h0; e_wdata = 32'h0; e_be = 4'h0;
        if (winner == 2) begin
            e_addr = da; e_wdata = dwd; e_be = dw ? dbe : 4'hF;
        end else if (winner == 1) begin
            e_addr = ia; e_be = 4'hF;
        end

        check("i_gnt", 32'(i_gnt), 32'(winner == 1));
        check("d_gnt", 32'(d_gnt), 32'(winner == 2));
        check("m_en", 32'(m_en), 32'(winner != 0));
        check("m_we", 32'(m_we), 32'(winner == 2 && dw));
        check("m_addr", m_addr, e_addr);
        check("m_wdata", m_wdata, e_wdata);
        check("m_be", 32'(m_be), 32'(e_be));
        check("i_rvalid", 32'(i_rvalid), 32'(mdl_owner == 1));
        check("d_rvalid", 32'(d_rvalid), 32'(mdl_owner == 2));
        check("i_rdata", i_rdata, (mdl_owner == 1) ? mdl_resp : mdl_ihold);
        check("d_rdata", d_rdata, (mdl_owner == 2) ? mdl_resp : mdl_dhold);

        if (r) begin
            mdl_waits = 0; mdl_owner = 0; mdl_resp = 0; mdl_ihold = 0; mdl_dhold = 0;
        end else begin
            if (mdl_owner == 1) mdl_ihold = mdl_resp;
            if (mdl_owner == 2) mdl_dhold = mdl_resp;
            mdl_owner = 0;
            if (winner == 1) begin
                mdl_owner = 1; mdl_resp = ref_mem[ia[9:2]];
            end else if (winner == 2 && !dw) begin
                mdl_owner = 2; mdl_resp = ref_mem[da[9:2]];
            end else if (winner == 2) begin
                word = ref_mem[da[9:2]];
                for (int b = 0; b < 4; b++) if (dbe[b]) word[8*b +: 8] = dwd[8*b +: 8];
                ref_mem[da[9:2]] = word;
            end
            if (ir && winner == 2) mdl_waits = (mdl_waits < int'(STARVE_LIMIT)) ? mdl_waits + 1
                                                                             : mdl_waits;
            else mdl_waits = 0;
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    logic        r_ir, r_dr, r_dw, r_rst;
    logic [31:0] r_ia, r_da, r_dwd;
    logic [3:0]  r_be;

    initial begin
        for (int k = 0; k < 256; k++) begin
            env_mem[k] = 32'h5A000000 ^ (k * 32'h00010203);
            ref_mem[k] = 32'h5A000000 ^ (k * 32'h00010203);
        end
        env_mem[8'h40] = 32'hDEADBEEF;
        ref_mem[8'h40] = 32'hDEADBEEF;
        mdl_waits = 0; mdl_owner = 0; mdl_resp = 0; mdl_ihold = 0; mdl_dhold = 0;
        rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_be = '0;

        // Reset then idle
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        idle(2);

        // Fetch read returning DEADBEEF, then held value
        step(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        idle(3);

        // Conflict: data wins, fetch follows once data drops
        step(1'b0, 1'b1, 32'h104, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
        step(1'b0, 1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        idle(2);

        // Starvation: both held for 10 cycles
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
        idle(2);

        // Byte-enabled store, then read back the merged word
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h304, 32'h00AB0000, 4'b0100);
        idle(1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h304, 32'h0, 4'h0);
        idle(1);

        // Reset during a data read with a partially built starvation count
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 32'h108, 1'b1, 1'b0, 32'h20C, 32'h0, 4'h0);
        step(1'b1, 1'b1, 32'h108, 1'b1, 1'b0, 32'h20C, 32'h0, 4'h0);
        idle(1);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 32'h108, 1'b1, 1'b0, 32'h20C, 32'h0, 4'h0);
        idle(1);

        // Randomized traffic; requests usually persist across cycles
        r_ir = 0; r_dr = 0; r_dw = 0; r_ia = 0; r_da = 0; r_dwd = 0; r_be = 0;
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                r_ir = $urandom_range(0, 1) == 1;
                r_ia = {22'h0, 8'($urandom), 2'b00};
            end
            if ($urandom_range(0, 3) == 0) begin
                r_dr  = $urandom_range(0, 1) == 1;
                r_dw  = $urandom_range(0, 2) == 0;
                r_da  = {22'h0, 8'($urandom), 2'b00};
                r_dwd = $urandom;
                r_be  = 4'($urandom);
            end
            r_rst = $urandom_range(0, 63) == 0;
            step(r_rst, r_ir, r_ia, r_dr, r_dw, r_da, r_dwd, r_be);
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
